// File: rtl/r_pkg.sv
// Shared types and line levels for the serial transmitter path.
package r_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Counter width that stays legal when a count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/r_bit_timer.sv
// Bit-period timer: tick marks the last cycle of each period, pre_tick the cycle before it.
module r_bit_timer
  import r_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

  // pre_tick lets the parent register a pulse that lands exactly on the tick cycle.
  generate
    if (CLKS_PER_BIT == 1) begin : g_single
      assign pre_tick = 1'b1;
    end else begin : g_multi
      assign pre_tick = !clear && (cnt == CW'(CLKS_PER_BIT - 2));
    end
  endgenerate

endmodule

// File: rtl/r_serial_tx.sv
// Parallel-to-serial transmitter: start bit, WIDTH data bits, stop bit, each CLKS_PER_BIT cycles.
module r_serial_tx
  import r_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shift_q, shift_n, shifted;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic             tx_n, ready_n, busy_n, done_n;
  logic             accept, tick, pre_tick;

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != 0) return v << 1;
    else                return v >> 1;
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != 0) return v[WIDTH-1];
    else                return v[0];
  endfunction

  assign accept = load && ready;

  // Clearing on acceptance aligns every bit period to the accept edge.
  r_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      tx      <= IDLE_LEVEL;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      bit_cnt <= bit_cnt_n;
      tx      <= tx_n;
      ready   <= ready_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    bit_cnt_n = bit_cnt;
    tx_n      = tx;
    ready_n   = ready;
    busy_n    = busy;
    shifted   = shift_once(shift_q);

    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = START;
          shift_n   = d;
          bit_cnt_n = '0;
          tx_n      = START_LEVEL;
          ready_n   = 1'b0;
          busy_n    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          tx_n      = head_bit(shift_q);
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_n = STOP;
            tx_n    = STOP_LEVEL;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            shift_n   = shifted;
            tx_n      = head_bit(shifted);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          tx_n    = IDLE_LEVEL;
          ready_n = 1'b1;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = IDLE_LEVEL;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    done_n = (state_n == STOP) && pre_tick;
  end

endmodule

// File: tb/tb_r_serial_tx.sv
// Self-checking bench for r_serial_tx: per-cycle scoreboard on the default build, hand checks on an MSB-first C=1 build.
module tb_r_serial_tx;

  typedef struct {
    logic tx;
    logic busy;
    logic ready;
    logic done;
    int   cyc;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0, d1;
  logic       load0, load1;
  logic       ready0, tx0, busy0, done0;
  logic       ready1, tx1, busy1, done1;

  exp_t sb[$];
  vec_t vectors[4];
  int   total  = 0;
  int   passed = 0;

  r_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .d(d0), .load(load0),
    .ready(ready0), .tx(tx0), .busy(busy0), .done(done0)
  );

  r_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1)) dut1 (
    .clk(clk), .reset(reset), .d(d1), .load(load1),
    .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int cyc, input logic actual, input logic expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s @cyc%0d: got %b, expected %b", name, cyc, actual, expected);
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) sb.push_back('{tx: 1'b1, busy: 1'b0, ready: 1'b1, done: 1'b0, cyc: -1});
  endtask

  // Frame string is in transmission order, MSB of the 10-bit value first; C=4 cycles per bit.
  task automatic pushFrame(input logic [9:0] frame, input int ncyc);
    for (int i = 1; i <= ncyc; i++) begin
      if (i <= 40) sb.push_back('{tx: frame[9 - (i - 1) / 4], busy: 1'b1, ready: 1'b0, done: (i == 40), cyc: i});
      else         sb.push_back('{tx: 1'b1, busy: 1'b0, ready: 1'b1, done: 1'b0, cyc: i});
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic [9:0] frame, input bit hold, input int ncyc);
    @(negedge clk);
    d0    = data;
    load0 = 1'b1;
    @(posedge clk);
    #1;
    pushFrame(frame, ncyc);
    if (!hold) load0 = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      $display("[TB] FAIL %s: %0d expected cycles left, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput("tx",    e.cyc, tx0,    e.tx);
      checkOutput("busy",  e.cyc, busy0,  e.busy);
      checkOutput("ready", e.cyc, ready0, e.ready);
      checkOutput("done",  e.cyc, done0,  e.done);
    end
  end

  initial begin
    logic [9:0] exp1;

    vectors[0] = '{d: 8'hA5, frame: 10'b0_10100101_1};
    vectors[1] = '{d: 8'h00, frame: 10'b0_00000000_1};
    vectors[2] = '{d: 8'hFF, frame: 10'b0_11111111_1};
    vectors[3] = '{d: 8'h81, frame: 10'b0_10000001_1};

    reset = 1'b1;
    load0 = 1'b1;
    d0    = 8'hFF;
    load1 = 1'b0;
    d1    = 8'h00;

    // Reset held with load high: the line must stay idle and nothing starts.
    @(posedge clk);
    #1;
    pushIdle(4);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    load0 = 1'b0;
    waitDrain("reset_idle");

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vectors[v].d, vectors[v].frame, 1'b0, 41);
      waitDrain("table_frame");
    end

    // load held high: two frames with one idle cycle between, d changed mid-frame.
    applyStimulus(8'h3C, 10'b0_00111100_1, 1'b1, 41);
    repeat (20) @(posedge clk);
    #1 d0 = 8'hC3;
    repeat (21) @(posedge clk);
    #1;
    pushFrame(10'b0_11000011_1, 41);
    load0 = 1'b0;
    waitDrain("back_to_back");

    // Reset during a frame aborts it cleanly, then a fresh frame goes out whole.
    applyStimulus(8'h55, 10'b0_10101010_1, 1'b0, 15);
    pushIdle(5);
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    waitDrain("reset_abort");
    applyStimulus(8'h0F, 10'b0_11110000_1, 1'b0, 41);
    waitDrain("after_abort");

    // load while busy is ignored; the line stays idle afterwards.
    applyStimulus(8'h3C, 10'b0_00111100_1, 1'b0, 41);
    pushIdle(8);
    repeat (10) @(negedge clk);
    d0    = 8'h99;
    load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    waitDrain("load_while_busy");

    // MSB-first, one clock per bit.
    exp1 = 10'b0000000011;
    @(negedge clk);
    d1    = 8'h01;
    load1 = 1'b1;
    @(posedge clk);
    #1 load1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checkOutput("msb_tx",   i, tx1,   exp1[10 - i]);
      checkOutput("msb_done", i, done1, (i == 10));
    end
    @(negedge clk);
    checkOutput("msb_ready", 11, ready1, 1'b1);
    checkOutput("msb_busy",  11, busy1,  1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
